// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory loader.
// LOADER_CHECKSUM_EN adds the CHK state and a trailing checksum byte to the stream.
package imem_loader_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int BYTES_PER_WORD = 2;
    localparam int WORD_W         = BYTES_PER_WORD * 8;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        RX_HI = 3'd1,
        RX_LO = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHK   = 3'd3,
`endif
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    // A header count of zero stands for a full memory image.
    function automatic int full_count(input int addr_w);
        return 2 ** addr_w;
    endfunction

    // Counter must hold both the 8-bit header value and 2^ADDR_W.
    function automatic int cnt_width(input int addr_w);
        return ((addr_w > 8) ? addr_w : 8) + 1;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = stream producer / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::DEFAULT_ADDR_W
);
    logic                              rx_valid;
    logic [7:0]                        rx_data;
    logic                              rx_ready;
    logic                              wr_en;
    logic [ADDR_W-1:0]                 wr_addr;
    logic [imem_loader_pkg::WORD_W-1:0] wr_data;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader_checksum.sv
// 8-bit running sum of payload bytes with clear and a zero test that
// includes the byte currently on din (used for the trailing checksum byte).
module loader_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       acc,
    input  logic [7:0] din,
    output logic       total_zero
);
    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = 8'h00;
        end else if (acc) begin
            sum_d = sum_q + din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign total_zero = ((sum_q + din) == 8'h00);
endmodule

// File: rtl/imem_loader.sv
// Boot loader: turns a counted byte stream into instruction-memory writes
// and holds the core in reset until the image is in. Option: LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus,
    input  logic          reload,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_error
);
    localparam int                CNT_W = cnt_width(ADDR_W);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [7:0]          hi_q,      hi_d;
    logic                wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;

    logic rx_state;
    logic accept;

`ifdef LOADER_CHECKSUM_EN
    logic sum_clr;
    logic sum_acc;
    logic total_zero;

    loader_checksum u_checksum (
        .clk        (clk),
        .rst        (reset),
        .clr        (sum_clr),
        .acc        (sum_acc),
        .din        (bus.rx_data),
        .total_zero (total_zero)
    );

    assign rx_state = (state_q == HDR) || (state_q == RX_HI) ||
                      (state_q == RX_LO) || (state_q == CHK);
`else
    assign rx_state = (state_q == HDR) || (state_q == RX_HI) ||
                      (state_q == RX_LO);
`endif

    // Gating with reset keeps rx_ready low while reset is held.
    assign bus.rx_ready = rx_state & ~reset;
    assign accept       = bus.rx_valid & bus.rx_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_en_q ? (wr_addr_q + 1'b1) : wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_clr   = 1'b0;
        sum_acc   = 1'b0;
`endif
        case (state_q)
            HDR: begin
                if (accept) begin
                    cnt_d   = (bus.rx_data == 8'h00) ? CNT_W'(full_count(ADDR_W))
                                                     : CNT_W'(bus.rx_data);
                    state_d = RX_HI;
                end
            end
            RX_HI: begin
                if (accept) begin
                    hi_d    = bus.rx_data;
                    state_d = RX_LO;
`ifdef LOADER_CHECKSUM_EN
                    sum_acc = 1'b1;
`endif
                end
            end
            RX_LO: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = {hi_q, bus.rx_data};
`ifdef LOADER_CHECKSUM_EN
                    sum_acc   = 1'b1;
`endif
                    if (cnt_q == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = RX_HI;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = total_zero ? DONE : ERR;
                end
            end
`endif
            DONE, ERR: begin
                if (reload) begin
                    state_d   = HDR;
                    wr_addr_d = BASE;
`ifdef LOADER_CHECKSUM_EN
                    sum_clr   = 1'b1;
`endif
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HDR;
            cnt_q     <= '0;
            hi_q      <= 8'h00;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign core_hold   = (state_q != DONE);
    assign load_done   = (state_q == DONE);
`ifdef LOADER_CHECKSUM_EN
    assign load_error  = (state_q == ERR);
`else
    assign load_error  = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; streams are hand-built and the expected
// write log is computed here. Define LOADER_CHECKSUM_EN to cover the checksum build.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reload = 1'b0;
    logic core_hold;
    logic load_done;
    logic load_error;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .reload     (reload),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t log_q[$];
    int  checks = 0;
    int  errors = 0;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            log_q.push_back('{a: bus.wr_addr, d: bus.wr_data});
            $display("write addr=%02h data=%04h", bus.wr_addr, bus.wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("rx_ready_timeout", 32'(n), 0);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] bytes[$], input bit gap, input bit add_chk);
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 1; i < bytes.size(); i++) sum = sum + bytes[i];
`ifdef LOADER_CHECKSUM_EN
        if (add_chk) bytes.push_back(8'h00 - sum);
`else
        if (add_chk) sum = 8'h00;
`endif
        for (int i = 0; i < bytes.size(); i++) begin
            if (gap && i > 0) tick();
            send_byte(bytes[i]);
        end
    endtask

    task automatic do_reload(input logic [7:0] with_byte);
        tick();
        reload       = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = with_byte;
        check("reload_rx_ready_low", 32'(bus.rx_ready), 0);
        @(posedge clk);
        #1;
        reload       = 1'b0;
        bus.rx_valid = 1'b0;
        check("reload_in_hdr_ready", 32'(bus.rx_ready), 1);
        check("reload_core_hold", 32'(core_hold), 1);
        check("reload_done_low", 32'(load_done), 0);
        check("reload_addr_base", 32'(bus.wr_addr), 0);
        log_q.delete();
    endtask

    task automatic check_basic_log(input string tag);
        check({tag, "_nwrites"}, 32'(log_q.size()), 2);
        if (log_q.size() == 2) begin
            check({tag, "_a0"}, 32'(log_q[0].a), 32'h00);
            check({tag, "_d0"}, 32'(log_q[0].d), 32'h1234);
            check({tag, "_a1"}, 32'(log_q[1].a), 32'h01);
            check({tag, "_d1"}, 32'(log_q[1].d), 32'hABCD);
        end
    endtask

    initial begin
        logic [7:0] s[$];
        int bad;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        tick();
        check("rst_rx_ready", 32'(bus.rx_ready), 0);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        check("rst_core_hold", 32'(core_hold), 1);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_load_error", 32'(load_error), 0);
        tick();
        reset = 1'b0;
        tick();
        check("hdr_rx_ready", 32'(bus.rx_ready), 1);

        // Basic two-word image, back to back
        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_stream(s, 1'b0, 1'b1);
        tick();
        tick();
        check_basic_log("b2b");
        check("b2b_load_done", 32'(load_done), 1);
        check("b2b_core_hold", 32'(core_hold), 0);
        check("b2b_rx_ready", 32'(bus.rx_ready), 0);
        check("b2b_load_error", 32'(load_error), 0);

        // Reload collides with a valid byte; that byte must be dropped
        do_reload(8'h55);
        s = '{8'h01, 8'hBE, 8'hEF};
        send_stream(s, 1'b0, 1'b1);
        tick();
        tick();
        check("rl_nwrites", 32'(log_q.size()), 1);
        if (log_q.size() == 1) begin
            check("rl_a0", 32'(log_q[0].a), 0);
            check("rl_d0", 32'(log_q[0].d), 32'hBEEF);
        end
        check("rl_load_done", 32'(load_done), 1);

        // Same image with one idle cycle between bytes
        do_reload(8'h00);
        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_stream(s, 1'b1, 1'b1);
        tick();
        tick();
        check_basic_log("gap");
        check("gap_load_done", 32'(load_done), 1);

        // Count 0 means the full 256-word space
        do_reload(8'h00);
        s = '{8'h00};
        for (int i = 0; i < 256; i++) begin
            s.push_back(8'(i));
            s.push_back(8'(i) ^ 8'hFF);
        end
        send_stream(s, 1'b0, 1'b1);
        repeat (4) tick();
        check("full_nwrites", 32'(log_q.size()), 256);
        bad = 0;
        for (int i = 0; i < log_q.size() && i < 256; i++) begin
            if (log_q[i].a !== 8'(i) || log_q[i].d !== {8'(i), 8'(i) ^ 8'hFF}) bad++;
        end
        check("full_content_bad", 32'(bad), 0);
        if (log_q.size() == 256) check("full_last_addr", 32'(log_q[255].a), 32'hFF);
        check("full_load_done", 32'(load_done), 1);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum: 0x10 + 0x20 + 0xD0 = 0x100
        do_reload(8'h00);
        s = '{8'h01, 8'h10, 8'h20, 8'hD0};
        send_stream(s, 1'b0, 1'b0);
        tick();
        tick();
        check("cks_ok_nwrites", 32'(log_q.size()), 1);
        if (log_q.size() == 1) begin
            check("cks_ok_a0", 32'(log_q[0].a), 0);
            check("cks_ok_d0", 32'(log_q[0].d), 32'h1020);
        end
        check("cks_ok_done", 32'(load_done), 1);
        check("cks_ok_error", 32'(load_error), 0);

        do_reload(8'h00);
        s = '{8'h01, 8'h10, 8'h20, 8'h00};
        send_stream(s, 1'b0, 1'b0);
        tick();
        tick();
        check("cks_bad_error", 32'(load_error), 1);
        check("cks_bad_done", 32'(load_done), 0);
        check("cks_bad_core_hold", 32'(core_hold), 1);
        check("cks_bad_rx_ready", 32'(bus.rx_ready), 0);
`endif

        // Reset in the middle of a 5-word load
        do_reload(8'h00);
        s = '{8'h05, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        send_stream(s, 1'b0, 1'b0);
        tick();
        check("mid_nwrites", 32'(log_q.size()), 3);
        if (log_q.size() == 3) check("mid_a2", 32'(log_q[2].a), 2);
        #2;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h44;
        reset = 1'b1;
        #1;
        check("mid_rst_rx_ready", 32'(bus.rx_ready), 0);
        check("mid_rst_wr_en", 32'(bus.wr_en), 0);
        check("mid_rst_wr_addr", 32'(bus.wr_addr), 0);
        check("mid_rst_core_hold", 32'(core_hold), 1);
        check("mid_rst_load_done", 32'(load_done), 0);
        bus.rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        log_q.delete();
        s = '{8'h01, 8'h77, 8'h88};
        send_stream(s, 1'b0, 1'b1);
        tick();
        tick();
        check("post_rst_nwrites", 32'(log_q.size()), 1);
        if (log_q.size() == 1) begin
            check("post_rst_a0", 32'(log_q[0].a), 0);
            check("post_rst_d0", 32'(log_q[0].d), 32'h7788);
        end
        check("post_rst_done", 32'(load_done), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
